// File: rtl/mem_pkg.sv
// Shared constants and FSM state encoding for the main memory responder.
// Module parameters default to these values.
package mem_pkg;

    localparam int DEF_ADR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_WORD_OFFSET   = 2;
    localparam int DEF_DATAMEM_WIDTH = 128;
    localparam int DEF_LINE_INDEX    = 6;
    localparam int DEF_LATENCY       = 2;
    localparam int CNT_WIDTH         = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_GAP,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/mem_line_array.sv
// Line storage: full-line write port, word-select combinational read port.
// Contents are never reset.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int WORD_OFFSET   = DEF_WORD_OFFSET,
    parameter int DATAMEM_WIDTH = DEF_DATAMEM_WIDTH,
    parameter int LINE_INDEX    = DEF_LINE_INDEX
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [LINE_INDEX-1:0]    wr_idx,
    input  logic [DATAMEM_WIDTH-1:0] wr_line,
    input  logic [LINE_INDEX-1:0]    rd_idx,
    input  logic [WORD_OFFSET-1:0]   rd_word,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam int NUM_LINES = 1 << LINE_INDEX;
    localparam int NUM_WORDS = 1 << WORD_OFFSET;

    logic [DATAMEM_WIDTH-1:0] lines [NUM_LINES];
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] rd_words;

    // Whole-line store in a single cycle
    always_ff @(posedge clk) begin
        if (we) begin
            lines[wr_idx] <= wr_line;
        end
    end

    assign rd_words = lines[rd_idx];
    assign rd_data  = rd_words[rd_word];

endmodule

// File: rtl/main_memory_responder.sv
// Main memory model answering cache-controller line refills with a
// four-beat burst and line writebacks with a single acknowledge.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int ADR_WIDTH     = DEF_ADR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int WORD_OFFSET   = DEF_WORD_OFFSET,
    parameter int DATAMEM_WIDTH = DEF_DATAMEM_WIDTH,
    parameter int LINE_INDEX    = DEF_LINE_INDEX,
    parameter int LATENCY       = DEF_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_cc2mem,
    input  logic [ADR_WIDTH-1:0]     adr_cc2mem,
    input  logic                     rdwr_cc2mem,
    input  logic [DATAMEM_WIDTH-1:0] dat_cc2mem,
    output logic                     ack_mem2cc,
    output logic [DATA_WIDTH-1:0]    dat_mem2cc,
    output logic [WORD_OFFSET-1:0]   word_mem2cc
);

    state_t                   state;
    logic [CNT_WIDTH-1:0]     cnt;
    logic [LINE_INDEX-1:0]    idx;
    logic                     rdwr;
    logic [DATAMEM_WIDTH-1:0] line;
    logic [WORD_OFFSET-1:0]   k;
    logic [WORD_OFFSET-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     we;
    logic                     unused_adr;

    // Tag bits alias and byte offset is ignored
    assign unused_adr = ^{adr_cc2mem[ADR_WIDTH-1:4+LINE_INDEX],
                          adr_cc2mem[3:0]};

    // The word fetched is the one the next BEAT will present
    assign rd_word = (state == S_GAP) ? k + 1'b1 : '0;
    assign we      = (state == S_WRITE);

    mem_line_array #(
        .DATA_WIDTH    (DATA_WIDTH),
        .WORD_OFFSET   (WORD_OFFSET),
        .DATAMEM_WIDTH (DATAMEM_WIDTH),
        .LINE_INDEX    (LINE_INDEX)
    ) u_array (
        .clk     (clk),
        .we      (we),
        .wr_idx  (idx),
        .wr_line (line),
        .rd_idx  (idx),
        .rd_word (rd_word),
        .rd_data (rd_data)
    );

    // Transaction FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            rdwr        <= 1'b0;
            line        <= '0;
            k           <= '0;
            ack_mem2cc  <= 1'b0;
            dat_mem2cc  <= '0;
            word_mem2cc <= '0;
        end else begin
            ack_mem2cc  <= 1'b0;
            dat_mem2cc  <= '0;
            word_mem2cc <= '0;
            case (state)
                S_IDLE: begin
                    if (req_cc2mem) begin
                        idx   <= adr_cc2mem[4 +: LINE_INDEX];
                        rdwr  <= rdwr_cc2mem;
                        line  <= dat_cc2mem;
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_WIDTH'(LATENCY - 1)) begin
                        ack_mem2cc <= 1'b1;
                        k          <= '0;
                        if (rdwr) begin
                            state <= S_WRITE;
                        end else begin
                            dat_mem2cc <= rd_data;
                            state      <= S_BEAT;
                        end
                    end
                end
                S_BEAT: begin
                    state <= S_GAP;
                end
                S_GAP: begin
                    if (&k) begin
                        state <= S_DONE;
                    end else begin
                        k           <= k + 1'b1;
                        ack_mem2cc  <= 1'b1;
                        dat_mem2cc  <= rd_data;
                        word_mem2cc <= k + 1'b1;
                        state       <= S_BEAT;
                    end
                end
                S_WRITE: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (!req_cc2mem) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized and directed bench for main_memory_responder against a
// line-array reference model with cycle-accurate ack expectations.
module tb_main_memory_responder;

    logic         clk;
    logic         rst;
    logic         req;
    logic [31:0]  adr_i;
    logic         rdwr_i;
    logic [127:0] dat_i;
    logic         ack;
    logic [31:0]  dat;
    logic [1:0]   word;

    logic [127:0] model [64];
    int           n_tests;
    int           n_fail;

    main_memory_responder dut (
        .clk         (clk),
        .rst         (rst),
        .req_cc2mem  (req),
        .adr_cc2mem  (adr_i),
        .rdwr_cc2mem (rdwr_i),
        .dat_cc2mem  (dat_i),
        .ack_mem2cc  (ack),
        .dat_mem2cc  (dat),
        .word_mem2cc (word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // One transaction; cycle c counts negedges after the capture edge.
    // Reads ack on cycles 3,5,7,9; a write acks on cycle 3 only.
    task automatic run_txn(input bit wr, input logic [31:0] adr,
                           input logic [127:0] wline, input int hold,
                           input int drop_c, input int abort_c);
        logic [127:0] exp_line;
        int           idx;
        bit           exp_ack;
        logic [1:0]   exp_w;
        idx      = int'(adr[9:4]);
        exp_line = model[idx];
        req      = 1'b1;
        adr_i    = adr;
        rdwr_i   = wr;
        dat_i    = wline;
        for (int c = 1; c <= 10 + hold; c++) begin
            @(negedge clk);
            exp_ack = wr ? (c == 3) : (c >= 3 && c <= 9 && (c % 2) == 1);
            exp_w   = wr ? 2'd0 : 2'((c - 3) / 2);
            if (exp_ack) begin
                check("ack", 128'(ack), 128'(1'b1));
                check("word", 128'(word), 128'(exp_w));
                if (!wr)
                    check("data", 128'(dat), 128'(exp_line[32*exp_w +: 32]));
            end else begin
                check("idle", 128'({ack, word, dat}), 128'(0));
            end
            if (c == 1) begin
                adr_i  = $urandom;
                dat_i  = {$urandom, $urandom, $urandom, $urandom};
                rdwr_i = 1'($urandom);
            end
            if (c == drop_c) req = 1'b0;
            if (c == abort_c) begin
                @(posedge clk);
                #2 rst = 1'b0;
                #1 check("rst_async", 128'({ack, word, dat}), 128'(0));
                req = 1'b0;
                break;
            end
        end
        if (wr) model[idx] = wline;
        req = 1'b0;
        if (abort_c != 0) begin
            repeat (3) begin
                @(negedge clk);
                check("rst_hold", 128'({ack, word, dat}), 128'(0));
            end
            rst = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] ln;
        logic [31:0]  a;
        bit           wr;
        int           hold;
        int           drop;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 64; i++) model[i] = '0;
        rst    = 1'b0;
        req    = 1'b0;
        adr_i  = '0;
        rdwr_i = 1'b0;
        dat_i  = '0;
        repeat (2) @(negedge clk);
        check("reset_ack", 128'(ack), 128'(0));
        check("reset_dat", 128'(dat), 128'(0));
        check("reset_word", 128'(word), 128'(0));
        rst = 1'b1;
        @(negedge clk);

        ln = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        run_txn(1'b1, 32'h0000_0D08, ln, 0, 0, 0);
        run_txn(1'b0, 32'h0000_0D08, '0, 0, 0, 0);
        run_txn(1'b0, 32'hFF07_BD08, '0, 0, 0, 0);
        run_txn(1'b0, 32'h0000_0D08, '0, 20, 0, 0);
        run_txn(1'b0, 32'h0000_0D08, '0, 0, 5, 0);
        run_txn(1'b0, 32'h0000_0D08, '0, 0, 0, 6);
        run_txn(1'b0, 32'hFF07_BD08, '0, 0, 0, 0);
        run_txn(1'b0, 32'h0000_0050, '0, 0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            wr   = 1'($urandom);
            a    = $urandom;
            a[9:4] = 6'($urandom_range(0, 3)) | 6'h20;
            ln   = {$urandom, $urandom, $urandom, $urandom};
            hold = $urandom_range(0, 3);
            drop = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9) : 0;
            run_txn(wr, a, ln, hold, drop, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
